// File: rtl/prl_pkg.sv
// Shared encodings for the protocol-layer Hard/Cable Reset controller:
// one-hot states, reset kind, TRANSMIT/SOP* codes and ALERT bit positions.
package prl_pkg;

   typedef enum logic [6:0] {
      ST_IDLE      = 7'b000_0001,
      ST_WAIT_REQ  = 7'b000_0010,
      ST_CONSTRUCT = 7'b000_0100,
      ST_WAIT_PHY  = 7'b000_1000,
      ST_SUCCESS   = 7'b001_0000,
      ST_FAILURE   = 7'b010_0000,
      ST_REPORT    = 7'b100_0000
   } state_e;

   typedef enum logic {
      KIND_HARD  = 1'b0,
      KIND_CABLE = 1'b1
   } kind_e;

   localparam logic [3:0] TX_NONE        = 4'b0000;
   localparam logic [3:0] TX_HARD_RESET  = 4'b0101;
   localparam logic [3:0] TX_CABLE_RESET = 4'b0110;

   localparam logic [2:0] SOP_NONE  = 3'b000;
   localparam logic [2:0] SOP_HARD  = 3'b101;
   localparam logic [2:0] SOP_CABLE = 3'b110;

   localparam int ALERT_TX_SUCCESS_BIT = 6;
   localparam int ALERT_TX_FAILED_BIT  = 4;

   function automatic logic [3:0] transmit_code(input kind_e kind);
      return (kind == KIND_CABLE) ? TX_CABLE_RESET : TX_HARD_RESET;
   endfunction

   function automatic logic [2:0] sop_code(input kind_e kind);
      return (kind == KIND_CABLE) ? SOP_CABLE : SOP_HARD;
   endfunction

endpackage

// File: rtl/prl_timeout_timer.sv
// tHardResetComplete timer: counts enabled cycles from a clear and holds at
// TIMEOUT_CYC-1, flagging expiry while it sits there.
module prl_timeout_timer
   import prl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 200
) (
   input  logic CLK,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int              CW   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/prl_hard_reset_ctrl.sv
// Hard/Cable Reset transmit controller: launches the reset signalling, waits
// for PHY completion with bounded retries, and reports the outcome in ALERT.
module prl_hard_reset_ctrl
   import prl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 200,
   parameter int MAX_RETRIES = 0,
   parameter int ALERT_W     = 16
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               hr_req,
   input  logic               cr_req,
   input  logic               PHY_Reset,
   input  logic [ALERT_W-1:0] alert_clr,
   output logic [3:0]         TRANSMIT,
   output logic               tx_start,
   output logic [2:0]         SOPMessage,
   output logic [ALERT_W-1:0] ALERT,
   output logic               busy,
   output logic [6:0]         state_o
);

   localparam int                 RW          = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [RW-1:0]      RETRY_LIMIT = RW'(MAX_RETRIES);
   localparam logic [ALERT_W-1:0] ALERT_USED  =
      ALERT_W'((1 << ALERT_TX_SUCCESS_BIT) | (1 << ALERT_TX_FAILED_BIT));

   state_e             state_q, state_d;
   kind_e              kind_q, kind_d;
   logic [RW-1:0]      retry_q, retry_d;
   logic               ok_q, ok_d;
   logic [ALERT_W-1:0] alert_q, alert_d;
   logic               timer_clear, timer_en, timer_expired;

   prl_timeout_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .CLK      (CLK),
      .reset    (reset),
      .clear_i  (timer_clear),
      .enable_i (timer_en),
      .expired_o(timer_expired)
   );

   // NOTE: every combinational output gets a default before the case so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      retry_d     = retry_q;
      ok_d        = ok_q;
      alert_d     = (alert_q & ~alert_clr) & ALERT_USED;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      tx_start    = 1'b0;
      TRANSMIT    = TX_NONE;
      SOPMessage  = SOP_NONE;
      busy        = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            busy    = 1'b0;
            state_d = ST_WAIT_REQ;
         end
         ST_WAIT_REQ: begin
            busy = 1'b0;
            if (hr_req || cr_req) begin
               kind_d  = hr_req ? KIND_HARD : KIND_CABLE;
               retry_d = '0;
               state_d = ST_CONSTRUCT;
            end
         end
         ST_CONSTRUCT: begin
            tx_start    = 1'b1;
            TRANSMIT    = transmit_code(kind_q);
            SOPMessage  = sop_code(kind_q);
            timer_clear = 1'b1;
            state_d     = ST_WAIT_PHY;
         end
         ST_WAIT_PHY: begin
            SOPMessage = sop_code(kind_q);
            timer_en   = 1'b1;
            // PHY completion is checked first so it wins in the expiry cycle.
            if (PHY_Reset) begin
               state_d = ST_SUCCESS;
            end else if (timer_expired) begin
               if (retry_q < RETRY_LIMIT) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_CONSTRUCT;
               end else begin
                  state_d = ST_FAILURE;
               end
            end
         end
         ST_SUCCESS: begin
            SOPMessage = sop_code(kind_q);
            ok_d       = 1'b1;
            state_d    = ST_REPORT;
         end
         ST_FAILURE: begin
            SOPMessage = sop_code(kind_q);
            ok_d       = 1'b0;
            state_d    = ST_REPORT;
         end
         ST_REPORT: begin
            SOPMessage = sop_code(kind_q);
            if (ok_q) begin
               alert_d[ALERT_TX_SUCCESS_BIT] = 1'b1;
            end else begin
               alert_d[ALERT_TX_FAILED_BIT] = 1'b1;
            end
            state_d = ST_WAIT_REQ;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         kind_q  <= KIND_HARD;
         retry_q <= '0;
         ok_q    <= 1'b0;
         alert_q <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         retry_q <= retry_d;
         ok_q    <= ok_d;
         alert_q <= alert_d;
      end
   end

   assign ALERT   = alert_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_prl_hard_reset_ctrl.sv
// Directed bench for prl_hard_reset_ctrl: a vector table for the basic flows,
// then hand-written timeout, retry, clear-priority and async-reset sequences.
module tb_prl_hard_reset_ctrl;

   localparam logic [6:0] S_IDLE = 7'h01;
   localparam logic [6:0] S_WREQ = 7'h02;
   localparam logic [6:0] S_CONS = 7'h04;
   localparam logic [6:0] S_WPHY = 7'h08;
   localparam logic [6:0] S_SUCC = 7'h10;
   localparam logic [6:0] S_FAIL = 7'h20;
   localparam logic [6:0] S_REP  = 7'h40;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;

   logic        hr0 = 1'b0, cr0 = 1'b0, phy0 = 1'b0;
   logic [15:0] clr0 = '0;
   logic [3:0]  tr0;
   logic        tx0, busy0;
   logic [2:0]  sop0;
   logic [15:0] alert0;
   logic [6:0]  st0;

   logic        hr1 = 1'b0, cr1 = 1'b0, phy1 = 1'b0;
   logic [15:0] clr1 = '0;
   logic [3:0]  tr1;
   logic        tx1, busy1;
   logic [2:0]  sop1;
   logic [15:0] alert1;
   logic [6:0]  st1;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   prl_hard_reset_ctrl dut0 (
      .CLK(CLK), .reset(reset), .hr_req(hr0), .cr_req(cr0), .PHY_Reset(phy0),
      .alert_clr(clr0), .TRANSMIT(tr0), .tx_start(tx0), .SOPMessage(sop0),
      .ALERT(alert0), .busy(busy0), .state_o(st0)
   );

   prl_hard_reset_ctrl #(.TIMEOUT_CYC(8), .MAX_RETRIES(2), .ALERT_W(16)) dut1 (
      .CLK(CLK), .reset(reset), .hr_req(hr1), .cr_req(cr1), .PHY_Reset(phy1),
      .alert_clr(clr1), .TRANSMIT(tr1), .tx_start(tx1), .SOPMessage(sop1),
      .ALERT(alert1), .busy(busy1), .state_o(st1)
   );

   typedef struct {
      logic        hr, cr, phy;
      logic [15:0] clr;
      logic [6:0]  st;
      logic        tx;
      logic [3:0]  tr;
      logic [2:0]  sop;
      logic [15:0] alert;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic hr, input logic cr, input logic phy, input logic [15:0] clr,
                      input logic [6:0] st, input logic tx, input logic [3:0] tr,
                      input logic [2:0] sop, input logic [15:0] alert, input logic busy);
      vec_t v;
      v.hr = hr; v.cr = cr; v.phy = phy; v.clr = clr;
      v.st = st; v.tx = tx; v.tr = tr; v.sop = sop; v.alert = alert; v.busy = busy;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all0(input string tag, input logic [6:0] st, input logic tx,
                             input logic [3:0] tr, input logic [2:0] sop,
                             input logic [15:0] alert, input logic busy);
      check({tag, " state"}, 32'(st0), 32'(st));
      check({tag, " tx_start"}, 32'(tx0), 32'(tx));
      check({tag, " TRANSMIT"}, 32'(tr0), 32'(tr));
      check({tag, " SOPMessage"}, 32'(sop0), 32'(sop));
      check({tag, " ALERT"}, 32'(alert0), 32'(alert));
      check({tag, " busy"}, 32'(busy0), 32'(busy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int pulses;
      logic sop_ok;

      // ---------------- reset state ----------------
      #2 reset = 1'b1;
      #1;
      check_all0("reset", S_IDLE, 1'b0, 4'h0, 3'h0, 16'h0, 1'b0);
      check("reset dut1 state", 32'(st1), 32'(S_IDLE));
      check("reset dut1 ALERT", 32'(alert1), 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) reset = 1'b0;

      // ---------------- vector table (dut0, TIMEOUT 200, no retries) ----------------
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0000, 0);
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0000, 0);
      add(1, 0, 0, 16'h0000, S_CONS, 1, 4'h5, 3'h5, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_WPHY, 0, 4'h0, 3'h5, 16'h0000, 1);
      for (int i = 0; i < 8; i++)
         add(i == 3, i == 5, 0, 16'h0000, S_WPHY, 0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 1, 16'h0000, S_SUCC, 0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_REP,  0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0040, 0);
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0040, 0);
      // both requests: HARD wins; clear of bit 6 with no set pending
      add(1, 1, 0, 16'h0040, S_CONS, 1, 4'h5, 3'h5, 16'h0000, 1);
      add(0, 0, 1, 16'h0000, S_WPHY, 0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 1, 16'h0000, S_SUCC, 0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_REP,  0, 4'h0, 3'h5, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0040, 0);
      add(0, 0, 0, 16'h0040, S_WREQ, 0, 4'h0, 3'h0, 16'h0000, 0);
      // cable reset
      add(0, 1, 0, 16'h0000, S_CONS, 1, 4'h6, 3'h6, 16'h0000, 1);
      add(0, 0, 1, 16'h0000, S_WPHY, 0, 4'h0, 3'h6, 16'h0000, 1);
      add(0, 0, 1, 16'h0000, S_SUCC, 0, 4'h0, 3'h6, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_REP,  0, 4'h0, 3'h6, 16'h0000, 1);
      add(0, 0, 0, 16'h0000, S_WREQ, 0, 4'h0, 3'h0, 16'h0040, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         hr0 = vecs[i].hr; cr0 = vecs[i].cr; phy0 = vecs[i].phy; clr0 = vecs[i].clr;
         step();
         check_all0($sformatf("row%0d", i), vecs[i].st, vecs[i].tx, vecs[i].tr,
                    vecs[i].sop, vecs[i].alert, vecs[i].busy);
      end
      hr0 = 0; cr0 = 0; phy0 = 0; clr0 = '0;

      // ---------------- cable reset timeout, no retries ----------------
      cr0 = 1; clr0 = 16'hFFFF;
      step();
      check("to cons state", 32'(st0), 32'(S_CONS));
      check("to cons TRANSMIT", 32'(tr0), 32'h6);
      cr0 = 0; clr0 = '0;
      step();
      check("to wphy entry", 32'(st0), 32'(S_WPHY));
      n = 0;
      sop_ok = 1'b1;
      while (st0 == S_WPHY && n < 400) begin
         if (sop0 !== 3'b110) sop_ok = 1'b0;
         step();
         n++;
      end
      check("to cycles in WAIT_PHY", 32'(n), 32'd200);
      check("to SOP during wait", 32'(sop_ok), 32'h1);
      check("to failure state", 32'(st0), 32'(S_FAIL));
      check("to failure SOP", 32'(sop0), 32'h6);
      step();
      check("to report", 32'(st0), 32'(S_REP));
      step();
      check_all0("to done", S_WREQ, 1'b0, 4'h0, 3'h0, 16'h0010, 1'b0);

      // ---------------- PHY_Reset exactly at expiry; set beats clear ----------------
      hr0 = 1; clr0 = 16'h0010;
      step();
      check("edge cons", 32'(st0), 32'(S_CONS));
      check("edge cleared ALERT", 32'(alert0), 32'h0);
      hr0 = 0; clr0 = '0;
      step();
      repeat (199) step();
      check("edge still waiting at 199", 32'(st0), 32'(S_WPHY));
      phy0 = 1;
      step();
      check("edge success wins", 32'(st0), 32'(S_SUCC));
      check("edge success SOP", 32'(sop0), 32'h5);
      phy0 = 0;
      step();
      check("edge report", 32'(st0), 32'(S_REP));
      clr0 = 16'h0040;
      step();
      check("edge set over clear", 32'(alert0), 32'h0040);
      step();
      check("edge later clear", 32'(alert0), 32'h0000);
      clr0 = '0;

      // ---------------- dut1: retries exhausted ----------------
      hr1 = 1;
      n = 0;
      pulses = 0;
      do begin
         step();
         hr1 = 0;
         n++;
         if (tx1 === 1'b1) pulses++;
      end while (st1 != S_WREQ && n < 100);
      check("retry steps to done", 32'(n), 32'd30);
      check("retry pulses", 32'(pulses), 32'd3);
      check("retry ALERT", 32'(alert1), 32'h0010);

      // ---------------- dut1: PHY_Reset on the 2nd attempt ----------------
      hr1 = 1; clr1 = 16'h0010;
      n = 0;
      pulses = 0;
      do begin
         step();
         hr1 = 0; clr1 = '0;
         n++;
         if (tx1 === 1'b1) pulses++;
         phy1 = (pulses == 2) && (st1 == S_WPHY);
      end while (st1 != S_WREQ && n < 100);
      phy1 = 0;
      check("retry2 steps to done", 32'(n), 32'd14);
      check("retry2 pulses", 32'(pulses), 32'd2);
      check("retry2 ALERT", 32'(alert1), 32'h0040);

      // ---------------- async reset mid-WAIT_PHY ----------------
      hr0 = 1;
      step();
      hr0 = 0;
      step();
      repeat (3) step();
      check("ar in wphy", 32'(st0), 32'(S_WPHY));
      #2 reset = 1'b1;
      #1;
      check_all0("ar immediate", S_IDLE, 1'b0, 4'h0, 3'h0, 16'h0, 1'b0);
      check("ar dut1 state", 32'(st1), 32'(S_IDLE));
      repeat (2) @(posedge CLK);
      @(negedge CLK) reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (tx0 === 1'b1) pulses++;
      end
      check("ar no tx_start", 32'(pulses), 32'd0);
      check_all0("ar after", S_WREQ, 1'b0, 4'h0, 3'h0, 16'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prl_hard_reset_ctrl.md
PRL_HARD_RESET_CTRL -- requirements
Module: prl_hard_reset_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK, and SHALL use reset as an asynchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYC, default 200: tHardResetComplete timeout in CLK cycles (>=2).
REQ-003 Parameter MAX_RETRIES, default 0: re-transmissions after a timeout before failure is declared.
REQ-004 Parameter ALERT_W, default 16: ALERT register width (>=7).
REQ-005 CLK  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 hr_req  in  1  Hard Reset request from policy engine, sampled only in WAIT_REQ.
REQ-008 cr_req  in  1  Cable Reset request, sampled only in WAIT_REQ.
REQ-009 PHY_Reset  in  1  PHY indicates reset signalling completed.
REQ-010 alert_clr  in  ALERT_W  write-1-to-clear mask for ALERT.
REQ-011 TRANSMIT  out  4  transmit command register value.
REQ-012 tx_start  out  1  one-cycle pulse launching PHY transmission.
REQ-013 SOPMessage  out  3  SOP* type of the reset in progress.
REQ-014 ALERT  out  ALERT_W  sticky alert register.
REQ-015 busy  out  1  high in every state except IDLE and WAIT_REQ.
REQ-016 state_o  out  7  current one-hot state, for debug.

Function
REQ-017 States SHALL be one-hot: IDLE, WAIT_REQ, CONSTRUCT, WAIT_PHY, SUCCESS, FAILURE, REPORT.
REQ-018 IDLE SHALL go unconditionally to WAIT_REQ on the next edge.
REQ-019 In WAIT_REQ, hr_req=1 SHALL latch kind=HARD and move to CONSTRUCT; cr_req alone SHALL latch kind=CABLE; if both are high, HARD SHALL win and cr_req SHALL be dropped.
REQ-020 Requests outside WAIT_REQ SHALL be ignored and SHALL NOT be queued.
REQ-021 In CONSTRUCT, for exactly one cycle: tx_start=1; TRANSMIT=4'b0101 (HARD) or 4'b0110 (CABLE); next state WAIT_PHY.
REQ-022 SOPMessage SHALL be 3'b101 (HARD) or 3'b110 (CABLE) from CONSTRUCT through REPORT, and 3'b000 otherwise.
REQ-023 TRANSMIT SHALL be 4'b0000 in every state except CONSTRUCT.
REQ-024 The timer SHALL be cleared on entry to WAIT_PHY and SHALL increment each cycle in WAIT_PHY, saturating at TIMEOUT_CYC-1; its width SHALL be clog2(TIMEOUT_CYC).
REQ-025 PHY_Reset=1 in WAIT_PHY SHALL go to SUCCESS, including in the cycle where the timer equals TIMEOUT_CYC-1 (success wins over timeout).
REQ-026 If the timer equals TIMEOUT_CYC-1 and PHY_Reset=0: if retry_cnt<MAX_RETRIES, increment retry_cnt and return to CONSTRUCT; otherwise go to FAILURE.
REQ-027 retry_cnt SHALL be cleared when a request is accepted in WAIT_REQ.
REQ-028 SUCCESS and FAILURE SHALL each last one cycle and then go to REPORT.
REQ-029 On the edge leaving REPORT, ALERT[6] (TransmitSuccessful) SHALL be set after SUCCESS, or ALERT[4] (TransmitSOPMessageFailed) after FAILURE; the next state SHALL be WAIT_REQ.
REQ-030 ALERT bits SHALL stay set until cleared through alert_clr; in the same cycle, set SHALL take priority over clear; unused bits SHALL read 0.
REQ-031 Latency: a request accepted at edge N gives tx_start=1 in cycle N+1; PHY_Reset seen at edge M gives an ALERT update at edge M+2.

Reset
REQ-032 When reset is asserted, state SHALL go to IDLE; timer, retry_cnt, kind, ALERT, TRANSMIT, SOPMessage, tx_start and busy SHALL all go to 0, independent of CLK.
REQ-033 Reset asserted mid-operation SHALL abort the sequence without any ALERT update and without a tx_start pulse.

Structure
REQ-034 Shared package prl_pkg SHALL hold the state encodings, the TRANSMIT and SOPMessage codes, and the ALERT bit indices.
REQ-035 The timeout counter SHALL be a separate sub-module, prl_timeout_timer (clear, enable, expired), parametrised by TIMEOUT_CYC.

Verification
REQ-036 hr_req pulse, PHY_Reset at 10 cycles -> tx_start once with TRANSMIT=0101, SOPMessage=101, ALERT=16'h0040.
REQ-037 cr_req, no PHY_Reset, TIMEOUT_CYC=200, MAX_RETRIES=0 -> FAILURE 200 cycles after entering WAIT_PHY, ALERT=16'h0010, SOPMessage=110 during the sequence.
REQ-038 MAX_RETRIES=2, no PHY_Reset -> exactly 3 tx_start pulses, then ALERT[4]=1; repeat with PHY_Reset on the 2nd attempt -> ALERT[6]=1 and 2 pulses.
REQ-039 hr_req and cr_req together -> TRANSMIT=0101; a hr_req issued while busy is ignored, giving only one tx_start.
REQ-040 PHY_Reset in the cycle the timer equals 199 -> SUCCESS; alert_clr=16'h0040 in the set cycle -> bit 6 stays 1; a later clear -> bit 6 = 0.
REQ-041 reset asserted asynchronously in WAIT_PHY -> immediate IDLE, all outputs 0, no ALERT change.
